elevator_call_scheduler: RTL and testbench

- Collects hall/car call buttons for every floor into a pending-call register.
- Picks the next target floor using LOOK scheduling: keep sweeping in the current direction while calls exist ahead, then reverse.
- Drives requested_floor of elevator_state_machine and holds the door open for a dwell period at each served floor.
- Sits between the ui_in call buttons and elevator_state_machine in tt_um_example.

---
 rtl/elevator_call_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// LOOK-scheduled elevator call collector: latches call buttons, picks the next target floor
// and holds the door open for a dwell period at each stop. Optional macro: DOOR_HOLD_EN.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = 4,
    parameter int DWELL_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
`ifdef DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAVEL = 2'd1,
        DOOR   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [FLOOR_W-1:0]      target_q, target_d;
    logic                    door_q, door_d;
    logic                    dir_q, dir_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_FLOORS-1:0]   cur_onehot;
    logic [NUM_FLOORS-1:0]   clr_mask;
    logic [NUM_FLOORS-1:0]   call_eff;
    logic                    above_found, below_found;
    logic [FLOOR_W-1:0]      above_sel, below_sel;
    logic                    here_pending;
    logic                    cur_oor;
    logic                    hold;

`ifdef DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    // Compare in 32 bits so NUM_FLOORS == 2**FLOOR_W does not wrap to zero.
    assign cur_oor = ({{(32-FLOOR_W){1'b0}}, current_floor} >= 32'(NUM_FLOORS));

    // Nearest pending floor strictly above (lowest) and strictly below (highest) the car.
    always_comb begin
        above_found = 1'b0;
        above_sel   = '0;
        below_found = 1'b0;
        below_sel   = '0;
        cur_onehot  = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending_q[f] && (FLOOR_W'(f) > current_floor)) begin
                above_found = 1'b1;
                above_sel   = FLOOR_W'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending_q[f] && (FLOOR_W'(f) < current_floor)) begin
                below_found = 1'b1;
                below_sel   = FLOOR_W'(f);
            end
            cur_onehot[f] = (FLOOR_W'(f) == current_floor);
        end
    end

    assign here_pending = |(pending_q & cur_onehot);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        door_d   = door_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        clr_mask = '0;
        call_eff = call_req;

        // While dwelling, the button of the floor being served is ignored.
        if (state_q == DOOR) begin
            call_eff = call_req & ~cur_onehot;
        end

        if (cur_oor) begin
            state_d  = IDLE;
            target_d = '0;
            door_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    target_d = current_floor;
                    if (here_pending) begin
                        state_d  = DOOR;
                        clr_mask = cur_onehot;
                        cnt_d    = DWELL_LOAD;
                        door_d   = 1'b1;
                    end else if (dir_q && above_found) begin
                        target_d = above_sel;
                        state_d  = TRAVEL;
                    end else if (below_found) begin
                        dir_d    = 1'b0;
                        target_d = below_sel;
                        state_d  = TRAVEL;
                    end else if (above_found) begin
                        dir_d    = 1'b1;
                        target_d = above_sel;
                        state_d  = TRAVEL;
                    end
                end
                TRAVEL: begin
                    if ((current_floor == target_q) && car_idle) begin
                        state_d  = DOOR;
                        clr_mask = cur_onehot;
                        cnt_d    = DWELL_LOAD;
                        door_d   = 1'b1;
                    end else if (dir_q && above_found && (above_sel < target_q)) begin
                        target_d = above_sel;
                    end else if (!dir_q && below_found && (below_sel > target_q)) begin
                        target_d = below_sel;
                    end
                end
                DOOR: begin
                    door_d = 1'b1;
                    if (hold) begin
                        cnt_d = DWELL_LOAD;
                    end else if (cnt_q == '0) begin
                        door_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    door_d  = 1'b0;
                end
            endcase
        end

        // Clear beats a simultaneous call for the same floor.
        pending_d = (pending_q | call_eff) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            target_q  <= '0;
            door_q    <= 1'b0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            door_q    <= door_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
        end
    end

    assign target_floor = target_q;
    assign pending      = pending_q;
    assign door_open    = door_q;
    assign dir_up       = dir_q;
    assign busy         = (state_q != IDLE) || (pending_q != '0);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: expectations are queued with the cycle at
// which they must hold and a negedge monitor pops and compares them.
module tb_elevator_call_scheduler;

    localparam int NF = 10;
    localparam int FW = 4;

    localparam int F_TGT   = 0;
    localparam int F_PEND  = 1;
    localparam int F_DOOR  = 2;
    localparam int F_DIR   = 3;
    localparam int F_STATE = 4;
    localparam int F_BUSY  = 5;

    localparam logic [15:0] S_IDLE   = 16'd0;
    localparam logic [15:0] S_TRAVEL = 16'd1;
    localparam logic [15:0] S_DOOR   = 16'd2;

    typedef struct {
        int          at;
        int          field;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] call_req;
    logic [FW-1:0] current_floor;
    logic          car_idle;
`ifdef DOOR_HOLD_EN
    logic          door_hold;
`endif
    logic [FW-1:0] target_floor;
    logic [NF-1:0] pending;
    logic          door_open;
    logic          dir_up;
    logic          busy;
    logic [1:0]    state_dbg;

    exp_t exp_q[$];
    int   cyc;
    int   n_tests;
    int   n_fail;

    elevator_call_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DWELL_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .call_req     (call_req),
        .current_floor(current_floor),
        .car_idle     (car_idle),
`ifdef DOOR_HOLD_EN
        .door_hold    (door_hold),
`endif
        .target_floor (target_floor),
        .pending      (pending),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // driver helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int delta, input int field, input logic [15:0] val,
                             input string name);
        exp_t e;
        e.at    = cyc + delta;
        e.field = field;
        e.val   = val;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic expect_reset_values(input string tag);
        expect_at(0, F_STATE, S_IDLE, {tag, "_state"});
        expect_at(0, F_PEND,  16'h000, {tag, "_pending"});
        expect_at(0, F_TGT,   16'd0, {tag, "_target"});
        expect_at(0, F_DOOR,  16'd0, {tag, "_door"});
        expect_at(0, F_DIR,   16'd1, {tag, "_dir_up"});
        expect_at(0, F_BUSY,  16'd0, {tag, "_busy"});
    endtask

    function automatic logic [15:0] actual_of(input int field);
        case (field)
            F_TGT:   return 16'(target_floor);
            F_PEND:  return 16'(pending);
            F_DOOR:  return 16'(door_open);
            F_DIR:   return 16'(dir_up);
            F_STATE: return 16'(state_dbg);
            default: return 16'(busy);
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
                logic [15:0] act;
                act = actual_of(exp_q[i].field);
                n_tests++;
                if (exp_q[i].at < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check for cycle %0d missed (now %0d)",
                             exp_q[i].name, exp_q[i].at, cyc);
                end else if (act !== exp_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
                             exp_q[i].name, cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        call_req      = '0;
        current_floor = '0;
        car_idle      = 1'b1;
`ifdef DOOR_HOLD_EN
        door_hold     = 1'b0;
`endif
        tick(3);
        expect_reset_values("reset");
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // A: call at floor 5 from floor 0
        expect_at(0, F_BUSY, 16'd0, "a_busy_idle");
        call_req = 10'h020;
        expect_at(1, F_PEND,  16'h020, "a_pending_set");
        expect_at(1, F_STATE, S_IDLE, "a_still_idle");
        expect_at(1, F_BUSY,  16'd1, "a_busy_pending");
        expect_at(2, F_TGT,   16'd5, "a_target5");
        expect_at(2, F_DIR,   16'd1, "a_dir_up");
        expect_at(2, F_STATE, S_TRAVEL, "a_travel");
        tick(1);
        call_req = '0;
        tick(1);
        car_idle = 1'b0;
        // pending 4..7 while travelling; nearest 4 retargets one cycle later
        call_req = 10'h0F0;
        expect_at(1, F_PEND, 16'h0F0, "a_pending_f0");
        expect_at(1, F_TGT,  16'd5, "a_target_hold5");
        expect_at(2, F_TGT,  16'd4, "a_retarget4");
        tick(1);
        call_req = '0;
        tick(2);
        rst_n = 1'b0;
        expect_reset_values("midtravel_rst");
        tick(2);
        rst_n         = 1'b1;
        car_idle      = 1'b1;
        current_floor = 4'd0;
        tick(1);

        // B: travel to 7, intermediate call at 4, calls behind (1) and beyond (9)
        call_req = 10'h080;
        tick(1);
        call_req = '0;
        tick(1);
        expect_at(0, F_TGT,   16'd7, "b_target7");
        expect_at(0, F_STATE, S_TRAVEL, "b_travel");
        expect_at(0, F_PEND,  16'h080, "b_pending80");
        car_idle      = 1'b0;
        current_floor = 4'd1;
        tick(1);
        current_floor = 4'd2;
        call_req      = 10'h212;
        expect_at(1, F_PEND, 16'h292, "b_pending292");
        expect_at(1, F_TGT,  16'd7, "b_target_still7");
        expect_at(2, F_TGT,  16'd4, "b_retarget4");
        tick(1);
        call_req = '0;
        tick(1);
        current_floor = 4'd3;
        tick(1);
        current_floor = 4'd4;
        expect_at(1, F_STATE, S_TRAVEL, "b_wait_car_idle");
        expect_at(1, F_TGT,   16'd4, "b_target4_arrive");
        tick(1);
        car_idle = 1'b1;
        expect_at(1,  F_DOOR,  16'd1, "b_door_open");
        expect_at(1,  F_PEND,  16'h282, "b_pending4_cleared");
        expect_at(1,  F_STATE, S_DOOR, "b_state_door");
        expect_at(16, F_DOOR,  16'd1, "b_door_last_cycle");
        expect_at(17, F_DOOR,  16'd0, "b_door_closed");
        expect_at(17, F_STATE, S_IDLE, "b_idle_after_door");
        expect_at(18, F_TGT,   16'd7, "b_next_target7");
        expect_at(18, F_STATE, S_TRAVEL, "b_travel_again");
        tick(20);

        // C: LOOK reversal from floor 5 with calls at 2 and 8
        rst_n         = 1'b0;
        current_floor = 4'd5;
        car_idle      = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        expect_at(0, F_TGT, 16'd5, "c_idle_target_follows");
        call_req = 10'h104;
        tick(1);
        call_req = '0;
        tick(1);
        expect_at(0, F_TGT,   16'd8, "c_target8_first");
        expect_at(0, F_DIR,   16'd1, "c_dir_up");
        expect_at(0, F_STATE, S_TRAVEL, "c_travel");
        current_floor = 4'd8;
        expect_at(1,  F_STATE, S_DOOR, "c_door8");
        expect_at(1,  F_PEND,  16'h004, "c_pending8_cleared");
        expect_at(16, F_TGT,   16'd8, "c_target_held_door");
        expect_at(17, F_STATE, S_IDLE, "c_idle");
        expect_at(17, F_DOOR,  16'd0, "c_door_closed");
        expect_at(18, F_DIR,   16'd0, "c_dir_down");
        expect_at(18, F_TGT,   16'd2, "c_target2");
        expect_at(18, F_STATE, S_TRAVEL, "c_travel_down");
        tick(18);
        // going down from 6: 4 lies between, 7 is behind
        car_idle      = 1'b0;
        current_floor = 4'd6;
        call_req      = 10'h090;
        expect_at(1, F_PEND, 16'h094, "c_pending94");
        expect_at(1, F_TGT,  16'd2, "c_target_still2");
        expect_at(2, F_TGT,  16'd4, "c_retarget4_down");
        tick(1);
        call_req = '0;
        tick(1);
        // out-of-range floor forces IDLE, target 0, keeps pending
        current_floor = 4'd12;
        expect_at(1, F_STATE, S_IDLE, "oor_idle");
        expect_at(1, F_TGT,   16'd0, "oor_target0");
        expect_at(1, F_PEND,  16'h094, "oor_pending_kept");
        expect_at(1, F_BUSY,  16'd1, "oor_busy");
        tick(2);

        // D: call at the car's floor while idle goes straight to DOOR
        rst_n         = 1'b0;
        current_floor = 4'd3;
        car_idle      = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        call_req = 10'h008;
        expect_at(1,  F_PEND,  16'h008, "d_pending3");
        expect_at(1,  F_TGT,   16'd3, "d_target3");
        expect_at(2,  F_STATE, S_DOOR, "d_door_direct");
        expect_at(2,  F_PEND,  16'h000, "d_clear_wins");
        expect_at(2,  F_TGT,   16'd3, "d_target_stays3");
        expect_at(2,  F_DOOR,  16'd1, "d_door_open");
        expect_at(5,  F_PEND,  16'h000, "d_call_ignored_in_door");
        expect_at(17, F_DOOR,  16'd1, "d_door_last_cycle");
        expect_at(18, F_DOOR,  16'd0, "d_door_closed");
        expect_at(18, F_STATE, S_IDLE, "d_idle");
        expect_at(18, F_BUSY,  16'd0, "d_not_busy");
        tick(10);
        call_req = '0;
        tick(10);

`ifdef DOOR_HOLD_EN
        // F: door_hold keeps the door open, then a full dwell follows
        call_req = 10'h008;
        tick(1);
        call_req = '0;
        tick(1);
        door_hold = 1'b1;
        expect_at(0,  F_DOOR, 16'd1, "h_door_open");
        expect_at(20, F_DOOR, 16'd1, "h_door_held20");
        expect_at(39, F_DOOR, 16'd1, "h_door_held39");
        tick(40);
        door_hold = 1'b0;
        expect_at(15, F_DOOR,  16'd1, "h_door_last_cycle");
        expect_at(16, F_DOOR,  16'd0, "h_door_closed");
        expect_at(16, F_STATE, S_IDLE, "h_idle");
        tick(18);
`endif

        tick(2);
        if (exp_q.size() != 0) begin
            n_tests += exp_q.size();
            n_fail  += exp_q.size();
            $display("FAIL scoreboard_drain: %0d expectations never checked, expected 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
